// File: rtl/power_pkg.sv
// power_pkg: widths, row type and collector state encoding shared with the power stage.
package power_pkg;
   localparam int OUT_DATA_WIDTH = 52;
   localparam int LANES = 4;
   localparam int N_ROWS = 2048;
   localparam int ROW_W = $clog2(N_ROWS);
   localparam int ADDR_W = $clog2(N_ROWS * LANES);
   localparam int LANE_W = $clog2(LANES);
   typedef logic [LANES*OUT_DATA_WIDTH-1:0] power_row_t;
   typedef enum logic [1:0] {IDLE, FILL, DRAIN} coll_state_e;
endpackage

// File: rtl/power_row_ram.sv
// power_row_ram: row memory with two write ports and one registered read port.
module power_row_ram
   import power_pkg::*;
(
   input  logic             clk,
   input  logic             we_a,
   input  logic [ROW_W-1:0] addr_a,
   input  power_row_t       wd_a,
   input  logic             we_b,
   input  logic [ROW_W-1:0] addr_b,
   input  power_row_t       wd_b,
   input  logic             rd_en,
   input  logic [ROW_W-1:0] rd_addr,
   output power_row_t       rd_data
);
   power_row_t mem [N_ROWS];
   // port b is written last so it wins when both ports hit the same row
   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wd_a;
      if (we_b) mem[addr_b] <= wd_b;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/power_collector.sv
// power_collector: scatters indexed power rows into a frame buffer, then drains
// the frame as a linear word stream under valid/ready.
module power_collector
   import power_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   input  logic                      col2_valid,
   input  power_row_t                col_1,
   input  power_row_t                col_2,
   input  logic [ROW_W-1:0]          index_col1,
   input  logic [ROW_W-1:0]          index_col2,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [OUT_DATA_WIDTH-1:0] m_data,
   output logic [ADDR_W-1:0]         m_addr,
   output logic                      m_last,
   output logic                      frame_short,
   output logic                      overflow,
   output logic                      dup_err
);
   coll_state_e state, state_nxt;
   logic [ROW_W:0] row_cnt, cnt_nxt;
   logic [ROW_W-1:0] rd_row;
   power_row_t cur_row, rd_data;
   logic acc, dup, we_b, hs, start, adv, rd_en;

   assign acc = in_valid && state != DRAIN;
   assign dup = col2_valid && index_col1 == index_col2;
   assign we_b = acc && col2_valid;
   assign hs = m_valid && m_ready;
   assign m_last = m_valid && &m_addr;
   // read-ahead: prime row 0, then fetch the next row whenever the current one is taken
   assign start = state == DRAIN && !m_valid && rd_row == ROW_W'(1);
   assign adv = hs && &m_addr[LANE_W-1:0] && !m_last;
   assign rd_en = state == DRAIN && (!m_valid || adv);
   assign m_data = cur_row[int'(m_addr[LANE_W-1:0])*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
   assign cnt_nxt = (state == IDLE ? '0 : row_cnt) + ((we_b && !dup) ? (ROW_W+1)'(2) : (ROW_W+1)'(1));

   power_row_ram u_ram (
      .clk(clk), .we_a(acc), .addr_a(index_col1), .wd_a(col_1),
      .we_b(we_b), .addr_b(index_col2), .wd_b(col_2),
      .rd_en(rd_en), .rd_addr(rd_row), .rd_data(rd_data)
   );

   always_comb begin
      state_nxt = state;
      if (state == DRAIN) state_nxt = (hs && m_last) ? IDLE : DRAIN;
      else if (in_valid) state_nxt = cnt_nxt >= (ROW_W+1)'(N_ROWS) ? DRAIN : FILL;
      else if (state == FILL) state_nxt = DRAIN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         row_cnt <= '0;
         rd_row <= '0;
         cur_row <= '0;
         m_valid <= 1'b0;
         m_addr <= '0;
         frame_short <= 1'b0;
         overflow <= 1'b0;
         dup_err <= 1'b0;
      end else begin
         state <= state_nxt;
         row_cnt <= acc ? cnt_nxt : (state_nxt == IDLE ? '0 : row_cnt);
         rd_row <= state == DRAIN ? rd_row + ROW_W'(rd_en) : '0;
         if (start || adv) cur_row <= rd_data;
         m_valid <= start ? 1'b1 : (hs && m_last ? 1'b0 : m_valid);
         if (hs) m_addr <= m_addr + ADDR_W'(1);
         frame_short <= (state == FILL && !in_valid) ? 1'b1 : (hs && m_last ? 1'b0 : frame_short);
         overflow <= overflow || (in_valid && state == DRAIN);
         dup_err <= dup_err || (acc && dup);
      end
   end
endmodule

// File: tb/tb_power_collector.sv
// tb_power_collector: directed frames with a scoreboard queue checked by a drain monitor.
module tb_power_collector;
   import power_pkg::*;
   logic clk = 0, rst = 1, in_valid = 0, col2_valid = 0, m_ready = 1;
   logic m_valid, m_last, frame_short, overflow, dup_err;
   power_row_t col_1 = '0, col_2 = '0;
   logic [ROW_W-1:0] index_col1 = '0, index_col2 = '0;
   logic [OUT_DATA_WIDTH-1:0] m_data;
   logic [ADDR_W-1:0] m_addr;
   typedef struct packed {logic [ADDR_W-1:0] a; logic [OUT_DATA_WIDTH-1:0] d; logic l;} exp_t;
   exp_t q[$];
   logic [OUT_DATA_WIDTH-1:0] mdl [N_ROWS*LANES];
   int n_cmp = 0, n_bad = 0, n_words = 0;
   bit rnd = 0;

   power_collector dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .col2_valid(col2_valid),
      .col_1(col_1), .col_2(col_2), .index_col1(index_col1), .index_col2(index_col2),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_addr(m_addr),
      .m_last(m_last), .frame_short(frame_short), .overflow(overflow), .dup_err(dup_err)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      exp_t e, p, cur;
      bit stall;
      stall = 0;
      p = '0;
      forever begin
         @(negedge clk);
         cur = {m_addr, m_data, m_last};
         if (stall) begin
            n_cmp++;
            if (!m_valid || cur !== p) begin
               n_bad++;
               $display("FAIL stall_hold: got v=%0b a=%0d d=%0h l=%0b expected v=1 a=%0d d=%0h l=%0b",
                        m_valid, cur.a, cur.d, cur.l, p.a, p.d, p.l);
            end
         end
         if (m_valid && m_ready) begin
            n_cmp++;
            n_words++;
            if (q.size() == 0) begin
               n_bad++;
               $display("FAIL extra_word: got a=%0d expected no word", m_addr);
            end else begin
               e = q.pop_front();
               if (cur !== e) begin
                  n_bad++;
                  $display("FAIL word: got a=%0d d=%0h l=%0b expected a=%0d d=%0h l=%0b",
                           cur.a, cur.d, cur.l, e.a, e.d, e.l);
               end
            end
         end
         stall = m_valid && !m_ready;
         p = cur;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic power_row_t mk(input int row, input logic [OUT_DATA_WIDTH-1:0] off);
      power_row_t r;
      for (int l = 0; l < LANES; l++) r[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH] = OUT_DATA_WIDTH'(row*LANES + l) + off;
      return r;
   endfunction

   task automatic wr(input logic v2, input int i1, input int i2, input power_row_t r1, input power_row_t r2, input bit upd);
      in_valid = 1;
      col2_valid = v2;
      index_col1 = ROW_W'(i1);
      index_col2 = ROW_W'(i2);
      col_1 = r1;
      col_2 = r2;
      if (upd) for (int l = 0; l < LANES; l++) mdl[i1*LANES + l] = r1[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      if (upd && v2) for (int l = 0; l < LANES; l++) mdl[i2*LANES + l] = r2[l*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int n, input logic [OUT_DATA_WIDTH-1:0] off);
      n_words = 0;
      wr(0, 0, 0, mk(0, off), '0, 1);
      if (n > 1) wr(0, 1, 0, mk(1, off), '0, 1);
      for (int k = 1; 2*k < n; k++) wr(2*k+1 < n, 2*k, 2*k+1, mk(2*k, off), mk(2*k+1, off), 1);
      in_valid = 0;
      col2_valid = 0;
   endtask

   task automatic push_frame();
      for (int a = 0; a < N_ROWS*LANES; a++) q.push_back({ADDR_W'(a), mdl[a], a == N_ROWS*LANES-1});
   endtask

   task automatic wait_valid(input int exp, input string nm);
      int n = 0;
      while (!m_valid && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, n, exp);
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while ((q.size() != 0 || m_valid) && n < 40000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({nm, "_words"}, n_words, N_ROWS*LANES);
      chk({nm, "_idle"}, dut.state, IDLE);
      chk({nm, "_short_clr"}, frame_short, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_addr", m_addr, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_short", frame_short, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_dup", dup_err, 0);
      chk("rst_state", dut.state, IDLE);
      chk("rst_row_cnt", dut.row_cnt, 0);
      rst = 0;
      @(posedge clk);
      #1;
      chk("idle_no_valid", m_valid, 0);

      fill(N_ROWS, '0);
      push_frame();
      wait_valid(2, "full_lat");
      chk("full_short", frame_short, 0);
      wait_drain("full");

      rnd = 1;
      fill(N_ROWS, '0);
      push_frame();
      wait_valid(2, "rnd_lat");
      wait_drain("rnd");
      rnd = 0;

      fill(100, 52'h10000000000);
      push_frame();
      @(posedge clk);
      #1;
      chk("part_drain_entry", dut.state, DRAIN);
      wait_valid(2, "part_lat");
      chk("part_short", frame_short, 1);
      wait_drain("part");

      chk("dup_cnt_pre", dut.row_cnt, 0);
      n_words = 0;
      wr(1, 5, 5, {LANES{52'd1}}, {LANES{52'd2}}, 1);
      chk("dup_cnt", dut.row_cnt, 1);
      chk("dup_err", dup_err, 1);
      in_valid = 0;
      col2_valid = 0;
      push_frame();
      wait_valid(3, "dup_lat");
      wr(1, 0, N_ROWS-1, {LANES{52'hF}}, {LANES{52'hF}}, 0);
      in_valid = 0;
      col2_valid = 0;
      chk("overflow", overflow, 1);
      wait_drain("dup");
      chk("dup_sticky", dup_err, 1);
      chk("ovf_sticky", overflow, 1);

      fill(10, 52'h20000000000);
      push_frame();
      n = 0;
      while (!(m_valid && m_addr == ADDR_W'(1000)) && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("rst_reach_1000", m_addr, 1000);
      rst = 1;
      #1;
      chk("abort_m_valid", m_valid, 0);
      chk("abort_m_addr", m_addr, 0);
      chk("abort_m_data", m_data, 0);
      chk("abort_m_last", m_last, 0);
      chk("abort_short", frame_short, 0);
      chk("abort_overflow", overflow, 0);
      chk("abort_dup", dup_err, 0);
      chk("abort_state", dut.state, IDLE);
      q.delete();
      @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk);
      #1;
      chk("abort_stays_idle", m_valid, 0);

      fill(N_ROWS, 52'h30000000000);
      push_frame();
      wait_valid(2, "post_rst_lat");
      wait_drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
